// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core memory stage: store-data forwarding
// select codes, the memory-access sequencer states and the zero register.
// ---------------------------------------------------------------------------
package mips_pkg;

    // forwardF select codes from the store-data forwarding unit
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_LOAD = 2'b01;
    localparam logic [1:0] FWD_ALU  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mem_state_t;

    // An instruction needs the data memory when it is a valid load or store.
    function automatic logic is_mem_op(input logic valid,
                                       input logic mem_to_reg,
                                       input logic mem_write);
        return valid & (mem_to_reg | mem_write);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// ---------------------------------------------------------------------------
// mem_access_fsm
// Sequences one data-memory access: waits for dmem_ack, counts WAIT cycles
// and aborts the access once TIMEOUT_CYCLES WAIT cycles pass without an ack.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem_op         instruction held in EX/MEM needs the data memory
//   dmem_ack       memory access complete this cycle
//   mem_stall      freeze upstream stages and EX/MEM
//   capture        MEM/WB takes the EX/MEM instruction normally
//   abort          ABORT cycle: MEM/WB takes the instruction with no result
//   in_idle        FSM is in IDLE (first MEM cycle of an instruction)
//   mem_timeout    sticky flag, set by any abort, cleared only by reset
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | first MEM cycle; non-memory ops and single-cycle accesses retire
// WAIT  | access outstanding, upstream stalled, counting toward timeout
// ABORT | one cycle: access dropped, instruction retires with no writeback
// ---------------------------------------------------------------------------
module mem_access_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_op,
    input  logic dmem_ack,
    output logic mem_stall,
    output logic capture,
    output logic abort,
    output logic in_idle,
    output logic mem_timeout
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    mem_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | abort;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !dmem_ack) begin
                    state_d   = WAIT;
                    cnt_d     = 8'd1;
                    mem_stall = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            WAIT: begin
                // an ack arriving on the last permitted cycle still completes
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    capture = 1'b1;
                end else if (cnt_q >= TIMEOUT_LIMIT) begin
                    state_d   = ABORT;
                    cnt_d     = 8'd0;
                    mem_stall = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    mem_stall = 1'b1;
                end
            end
            ABORT: begin
                abort   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign in_idle     = (state_q == IDLE);
    assign mem_timeout = timeout_q;

endmodule

// File: rtl/mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// mem_stage_pipe
// EX/MEM pipeline register, data-memory access sequencer and MEM/WB pipeline
// register for the 5-stage MIPS core. Store data is resolved from forwardF in
// the first MEM cycle and held for the rest of the access.
//
// Optional build macro: MEM_STAGE_PERF_EN adds perf_fwd_count and
// perf_stall_count saturating counters and their output ports.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   ex_*                               EX-stage instruction fields
//   flush                              squash the instruction entering MEM
//   forwardF                           store-data forward select
//   mem_rt, mem_write                  MEM-stage info for the forwarding unit
//   mem_stall                          freeze IF/ID/EX
//   dmem_req/we/addr/wdata/rdata/ack   data-memory interface
//   wb_*                               MEM/WB pipeline register outputs
//   mem_timeout                        sticky access-abort flag
//   perf_fwd_count, perf_stall_count   (MEM_STAGE_PERF_EN only)
// ---------------------------------------------------------------------------
module mem_stage_pipe
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_write_reg,
    input  logic [4:0]        ex_rt,
    input  logic              flush,
    input  logic [1:0]        forwardF,
    output logic [4:0]        mem_rt,
    output logic              mem_write,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_write_reg,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_load_data,
    output logic              mem_timeout
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_fwd_count,
    output logic [31:0]       perf_stall_count
`endif
);

    logic              exm_valid_q, exm_reg_write_q, exm_mem_to_reg_q, exm_mem_write_q;
    logic [DATA_W-1:0] exm_alu_result_q, exm_store_data_q;
    logic [4:0]        exm_write_reg_q, exm_rt_q;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]        wb_write_reg_q, wb_write_reg_d;
    logic [DATA_W-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [DATA_W-1:0] wb_load_data_q, wb_load_data_d;

    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] wdata_q;

    logic mem_op, stall, capture, abort, in_idle, timeout;

    assign mem_op = is_mem_op(exm_valid_q, exm_mem_to_reg_q, exm_mem_write_q);

    mem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_op      (mem_op),
        .dmem_ack    (dmem_ack),
        .mem_stall   (stall),
        .capture     (capture),
        .abort       (abort),
        .in_idle     (in_idle),
        .mem_timeout (timeout)
    );

    // EX/MEM: frozen while stalled, so a flush arriving mid-stall is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exm_valid_q      <= 1'b0;
            exm_reg_write_q  <= 1'b0;
            exm_mem_to_reg_q <= 1'b0;
            exm_mem_write_q  <= 1'b0;
            exm_alu_result_q <= '0;
            exm_store_data_q <= '0;
            exm_write_reg_q  <= REG_ZERO;
            exm_rt_q         <= REG_ZERO;
        end else if (!stall) begin
            if (flush) begin
                exm_valid_q      <= 1'b0;
                exm_reg_write_q  <= 1'b0;
                exm_mem_to_reg_q <= 1'b0;
                exm_mem_write_q  <= 1'b0;
                exm_alu_result_q <= '0;
                exm_store_data_q <= '0;
                exm_write_reg_q  <= REG_ZERO;
                exm_rt_q         <= REG_ZERO;
            end else begin
                exm_valid_q      <= ex_valid;
                exm_reg_write_q  <= ex_reg_write;
                exm_mem_to_reg_q <= ex_mem_to_reg;
                exm_mem_write_q  <= ex_mem_write;
                exm_alu_result_q <= ex_alu_result;
                exm_store_data_q <= ex_store_data;
                exm_write_reg_q  <= ex_write_reg;
                exm_rt_q         <= ex_rt;
            end
        end
    end

    // Forwarded values come from the MEM/WB register, which only holds the
    // producing instruction during the store's first MEM cycle.
    always_comb begin
        fwd_data = exm_store_data_q;
        case (forwardF)
            FWD_LOAD: fwd_data = wb_load_data_q;
            FWD_ALU:  fwd_data = wb_alu_result_q;
            default:  fwd_data = exm_store_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q <= '0;
        end else if (in_idle) begin
            wdata_q <= fwd_data;
        end
    end

    // Anything other than a capture or abort cycle is a stall: insert a bubble.
    always_comb begin
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_mem_to_reg_d = 1'b0;
        wb_write_reg_d  = REG_ZERO;
        wb_alu_result_d = '0;
        wb_load_data_d  = '0;
        if (capture || abort) begin
            wb_valid_d      = exm_valid_q;
            wb_reg_write_d  = exm_reg_write_q & ~abort;
            wb_mem_to_reg_d = exm_mem_to_reg_q;
            wb_write_reg_d  = exm_write_reg_q;
            wb_alu_result_d = exm_alu_result_q;
            if (capture && mem_op && dmem_ack) begin
                wb_load_data_d = dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_write_reg_q  <= REG_ZERO;
            wb_alu_result_q <= '0;
            wb_load_data_q  <= '0;
        end else begin
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_load_data_q  <= wb_load_data_d;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic        fwd_held_q;
    logic        fwd_now;
    logic [31:0] perf_fwd_q, perf_stall_q;

    // forwardF is only meaningful in IDLE; remember it for a waited store.
    assign fwd_now = in_idle ? ((forwardF == FWD_LOAD) || (forwardF == FWD_ALU))
                             : fwd_held_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_held_q   <= 1'b0;
            perf_fwd_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (in_idle) begin
                fwd_held_q <= fwd_now;
            end
            if (capture && mem_op && exm_mem_write_q && fwd_now && !(&perf_fwd_q)) begin
                perf_fwd_q <= perf_fwd_q + 32'd1;
            end
            if (stall && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fwd_count   = perf_fwd_q;
    assign perf_stall_count = perf_stall_q;
`endif

    assign mem_rt        = exm_rt_q;
    assign mem_write     = exm_mem_write_q;
    assign mem_stall     = stall;
    assign dmem_req      = mem_op & ~abort;
    assign dmem_we       = exm_mem_write_q;
    assign dmem_addr     = exm_alu_result_q;
    assign dmem_wdata    = in_idle ? fwd_data : wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_load_data  = wb_load_data_q;
    assign mem_timeout   = timeout;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_pipe
// Random instruction stream (with a directed prefix) through mem_stage_pipe
// against a transaction-level model: each instruction occupies MEM for
// (ack latency + 1) cycles, or TIMEOUT+2 cycles when it is aborted.
// ---------------------------------------------------------------------------
module tb_mem_stage_pipe;

    localparam int DW = 32;
    localparam int TO = 4;
    localparam int NEVER = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic [DW-1:0] ex_alu_result, ex_store_data;
    logic [4:0]    ex_write_reg, ex_rt;
    logic          flush;
    logic [1:0]    forwardF;
    logic [4:0]    mem_rt;
    logic          mem_write, mem_stall, dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ack;
    logic          wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]    wb_write_reg;
    logic [DW-1:0] wb_alu_result, wb_load_data;
    logic          mem_timeout;

    mem_stage_pipe #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_rt(ex_rt),
        .flush(flush), .forwardF(forwardF),
        .mem_rt(mem_rt), .mem_write(mem_write), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_write_reg(wb_write_reg),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid, rw, m2r, mw;
        logic [DW-1:0] alu, sdata, rdata;
        logic [4:0]    wreg, rt;
        logic [1:0]    fwd;
        int            lat;
    } instr_t;

    typedef struct {
        logic          valid, rw, m2r;
        logic [4:0]    wreg;
        logic [DW-1:0] alu, load;
    } wb_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 0; b.rw = 0; b.m2r = 0; b.mw = 0;
        b.alu = '0; b.sdata = '0; b.rdata = '0;
        b.wreg = '0; b.rt = '0; b.fwd = 2'b00; b.lat = 0;
        return b;
    endfunction

    function automatic instr_t mk(input logic rw, input logic m2r, input logic mw,
                                  input logic [DW-1:0] alu, input logic [DW-1:0] sdata,
                                  input logic [DW-1:0] rdata, input logic [4:0] wreg,
                                  input logic [4:0] rt, input logic [1:0] fwd, input int lat);
        instr_t r;
        r.valid = 1; r.rw = rw; r.m2r = m2r; r.mw = mw;
        r.alu = alu; r.sdata = sdata; r.rdata = rdata;
        r.wreg = wreg; r.rt = rt; r.fwd = fwd; r.lat = lat;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        int kind;
        r = bubble();
        kind    = $urandom_range(0, 2);
        r.valid = ($urandom_range(0, 9) != 0);
        r.rw    = (kind != 2);
        r.m2r   = (kind == 1);
        r.mw    = (kind == 2);
        r.alu   = $urandom;
        r.sdata = $urandom;
        r.rdata = $urandom;
        r.wreg  = 5'($urandom_range(1, 31));
        r.rt    = 5'($urandom_range(0, 31));
        r.fwd   = 2'($urandom_range(0, 3));
        r.lat   = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 5);
        return r;
    endfunction

    task automatic drive_ex(input instr_t i);
        ex_valid      = i.valid;
        ex_reg_write  = i.rw;
        ex_mem_to_reg = i.m2r;
        ex_mem_write  = i.mw;
        ex_alu_result = i.alu;
        ex_store_data = i.sdata;
        ex_write_reg  = i.wreg;
        ex_rt         = i.rt;
    endtask

    instr_t        dq[$];
    instr_t        cur, slot;
    wb_t           exp_wb, nxt;
    logic [DW-1:0] exp_wdata;
    logic          exp_tmo, ack, mop, exp_stall, exp_req, cur_dir, flush_cur;
    int            w;
    logic          seen_wait, prev_stall;

    initial begin
        // directed prefix: single-cycle store, lw->sw forward, slow load,
        // timed-out store, ALU op after abort, ack on the last WAIT cycle
        dq.push_back(mk(0, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         5'd0, 5'd9, 2'b00, 0));
        dq.push_back(mk(1, 1, 0, 32'h0000_2000, 32'h0,         32'h1234_5678, 5'd5, 5'd0, 2'b00, 2));
        dq.push_back(mk(0, 0, 1, 32'h0000_2004, 32'h1111_1111, 32'h0,         5'd0, 5'd5, 2'b01, 3));
        dq.push_back(mk(1, 1, 0, 32'h0000_3000, 32'h0,         32'hCAFE_0001, 5'd7, 5'd0, 2'b00, 2));
        dq.push_back(mk(0, 0, 1, 32'h0000_4000, 32'h5555_AAAA, 32'h0,         5'd0, 5'd3, 2'b00, NEVER));
        dq.push_back(mk(1, 0, 0, 32'h0000_00AB, 32'h0,         32'h0,         5'd3, 5'd0, 2'b10, 0));
        dq.push_back(mk(1, 1, 0, 32'h0000_5000, 32'h0,         32'hBEEF_0004, 5'd8, 5'd0, 2'b00, TO));
        dq.push_back(mk(0, 0, 1, 32'h0000_5004, 32'h2222_2222, 32'h0,         5'd0, 5'd8, 2'b01, 1));

        rst_n = 0; flush = 0; forwardF = 0; dmem_ack = 0; dmem_rdata = '0;
        cur = bubble(); slot = bubble(); cur_dir = 0; flush_cur = 0;
        drive_ex(cur);
        exp_wb = '{valid: 0, rw: 0, m2r: 0, wreg: '0, alu: '0, load: '0};
        exp_wdata = '0; exp_tmo = 0; w = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_dmem_req", dmem_req, 0);
        check_eq("rst_mem_stall", mem_stall, 0);
        check_eq("rst_timeout", mem_timeout, 0);
        check_eq("rst_wb_alu", wb_alu_result, 0);
        rst_n = 1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            mop = slot.valid & (slot.m2r | slot.mw);
            ack = mop && (w <= TO) && (w == slot.lat);
            dmem_ack   = ack;
            dmem_rdata = slot.rdata;
            forwardF   = (w == 0) ? slot.fwd : 2'($urandom_range(0, 3));
            #1;
            check_eq("wb_valid", wb_valid, exp_wb.valid);
            check_eq("wb_reg_write", wb_reg_write, exp_wb.rw);
            check_eq("wb_mem_to_reg", wb_mem_to_reg, exp_wb.m2r);
            check_eq("wb_write_reg", wb_write_reg, exp_wb.wreg);
            check_eq("wb_alu_result", wb_alu_result, exp_wb.alu);
            check_eq("wb_load_data", wb_load_data, exp_wb.load);
            check_eq("mem_timeout", mem_timeout, exp_tmo);
            check_eq("mem_rt", mem_rt, slot.rt);
            check_eq("mem_write", mem_write, slot.mw);

            exp_stall = mop && (w <= TO) && !ack;
            exp_req   = mop && (w <= TO);
            check_eq("mem_stall", mem_stall, exp_stall);
            check_eq("dmem_req", dmem_req, exp_req);

            if (w == 0) begin
                case (slot.fwd)
                    2'b01:   exp_wdata = exp_wb.load;
                    2'b10:   exp_wdata = exp_wb.alu;
                    default: exp_wdata = slot.sdata;
                endcase
            end
            if (exp_req) begin
                check_eq("dmem_we", dmem_we, slot.mw);
                check_eq("dmem_addr", dmem_addr, slot.alu);
                if (slot.mw) check_eq("dmem_wdata", dmem_wdata, exp_wdata);
            end

            if (exp_stall) begin
                nxt = '{valid: 0, rw: 0, m2r: 0, wreg: '0, alu: '0, load: '0};
            end else begin
                nxt.valid = slot.valid;
                nxt.rw    = slot.rw;
                nxt.m2r   = slot.m2r;
                nxt.wreg  = slot.wreg;
                nxt.alu   = slot.alu;
                if (mop && (w == TO + 1)) begin
                    nxt.rw   = 0;
                    nxt.load = '0;
                    exp_tmo  = 1;
                end else begin
                    nxt.load = ack ? slot.rdata : '0;
                end
            end

            @(posedge clk);
            #1;
            exp_wb = nxt;
            if (!exp_stall) begin
                slot = flush_cur ? bubble() : cur;
                w = 0;
                if (dq.size() > 0) begin
                    cur = dq.pop_front();
                    cur_dir = 1;
                end else begin
                    cur = rand_instr();
                    cur_dir = 0;
                end
                drive_ex(cur);
            end else begin
                w++;
            end
            flush_cur = cur_dir ? 1'b0 : ($urandom_range(0, 6) == 0);
            flush = flush_cur;
        end

        // asynchronous reset while an access is outstanding
        dmem_ack = 0;
        flush = 0;
        drive_ex(mk(0, 0, 1, 32'h0000_6000, 32'h7777_7777, 32'h0, 5'd0, 5'd1, 2'b00, NEVER));
        seen_wait = 0;
        prev_stall = 0;
        for (int k = 0; k < 40 && !seen_wait; k++) begin
            @(negedge clk);
            #1;
            if (mem_stall && prev_stall) seen_wait = 1;
            prev_stall = mem_stall;
        end
        check_eq("reach_wait", seen_wait, 1);
        #2;
        rst_n = 0;
        #1;
        check_eq("arst_dmem_req", dmem_req, 0);
        check_eq("arst_mem_stall", mem_stall, 0);
        check_eq("arst_wb_valid", wb_valid, 0);
        check_eq("arst_wb_reg_write", wb_reg_write, 0);
        check_eq("arst_wb_load_data", wb_load_data, 0);
        check_eq("arst_timeout", mem_timeout, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- EX/MEM pipeline register, data-memory access sequencer, and MEM/WB pipeline register for the 5-stage MIPS core.
- Consumes forwardF from the store-data forwarding unit to resolve lw→sw and ALU→sw store-data hazards.
- Supplies the forwarding unit its MEM-stage inputs (rt, memWrite) and WB-stage inputs (write reg, reg write, memToReg).
- Stalls the upstream pipeline while a data-memory access waits for acknowledge.

Parameters:
- DATA_W, 32, datapath width.
- TIMEOUT_CYCLES, 16, maximum WAIT-state cycles before the access is aborted; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX-stage instruction is valid
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_to_reg  in  1  EX instruction is a load
- ex_mem_write  in  1  EX instruction is a store
- ex_alu_result  in  DATA_W  address or ALU result
- ex_store_data  in  DATA_W  rt value read in ID/EX
- ex_write_reg  in  5  destination register
- ex_rt  in  5  store source register
- flush  in  1  squash the instruction entering MEM
- forwardF  in  2  00 = no forward, 01 = wb_load_data, 10 = wb_alu_result
- mem_rt  out  5  to forwarding unit (RegSw)
- mem_write  out  1  to forwarding unit (memWrite)
- mem_stall  out  1  freeze IF/ID/EX; upstream must hold its EX outputs stable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each
- wb_write_reg  out  5
- wb_alu_result, wb_load_data  out  DATA_W
- mem_timeout  out  1  sticky access-abort flag

Behaviour:
- Reset: all EX/MEM and MEM/WB fields 0; state = IDLE; wait counter 0; every output 0.
- EX/MEM capture:
  - Loads on each clk when mem_stall = 0.
  - flush = 1 with mem_stall = 0 loads a bubble (valid and all control bits 0).
  - flush during a stall is ignored.
- Memory-op definition: valid & (mem_to_reg | mem_write).
- Store data:
  - Resolved in the first MEM cycle (state IDLE) from forwardF.
  - forwardF 11 is treated as 00.
  - Value is latched into a wdata holding register.
  - dmem_wdata is driven from the mux in IDLE and from the holding register in WAIT, so data stays stable after WB advances.
- dmem_req = memory-op & state≠ABORT. dmem_we = mem_write. dmem_addr = EX/MEM alu_result.
- FSM:
  - IDLE:
    - Memory-op & dmem_ack → stay IDLE; MEM/WB captures (single-cycle access).
    - Memory-op & !dmem_ack → WAIT; counter = 1; mem_stall = 1.
  - WAIT: mem_stall = 1.
    - dmem_ack → IDLE; MEM/WB captures; mem_stall = 0 that cycle.
    - Counter = TIMEOUT_CYCLES & !dmem_ack → ABORT.
    - Otherwise counter += 1.
  - ABORT: one cycle, mem_stall = 0.
    - MEM/WB captures with wb_load_data = 0 and wb_reg_write forced to 0.
    - mem_timeout set (sticky until reset).
    - Next state IDLE.
- MEM/WB capture:
  - Non-memory-op instructions pass through in one cycle.
  - While mem_stall = 1, MEM/WB loads a bubble; WB-stage results are not replayed.
  - wb_load_data = dmem_rdata on ack.
- Simultaneous dmem_ack and timeout in the same cycle: ack wins.
- Reset mid-WAIT: returns to IDLE and drops dmem_req asynchronously.

Optional Feature:
- Macro MEM_STAGE_PERF_EN.
- When defined:
  - 32-bit outputs perf_fwd_count (stores completed with forwardF ≠ 00) and perf_stall_count (cycles with mem_stall = 1).
  - Both reset to 0 and saturate at all-ones.
- When undefined: neither port nor counters exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - FWD_NONE = 2'b00, FWD_LOAD = 2'b01, FWD_ALU = 2'b10.
  - mem_state_t {IDLE, WAIT, ABORT}.
  - REG_ZERO = 5'd0.
- One sub-module, mem_access_fsm: FSM, wait counter, timeout flag. Inputs: memory-op, dmem_ack. Outputs: mem_stall, capture strobe, abort strobe.

Test Plan:
- Store with dmem_ack tied high, forwardF = 00, ex_store_data = 0xDEADBEEF → dmem_wdata = 0xDEADBEEF in the same cycle, mem_stall never asserts.
- lw r5 → sw r5 with forwardF = 01 and wb_load_data = 0x12345678, dmem_ack delayed 3 cycles → dmem_wdata = 0x12345678 held for all 4 cycles, mem_stall high for 3 cycles, MEM/WB shows bubbles during the stall.
- Load with ack after 2 cycles, dmem_rdata = 0xCAFE0001 → wb_load_data = 0xCAFE0001, wb_reg_write = 1 one cycle after the ack.
- Store with ack never asserted, TIMEOUT_CYCLES = 4 → ABORT after 4 WAIT cycles, mem_timeout = 1, wb_reg_write = 0, pipeline resumes.
- flush with mem_stall = 0 → wb_valid = 0 next cycle. flush during WAIT → stalled instruction completes normally.
- rst_n pulsed low in WAIT → dmem_req = 0 and mem_stall = 0 immediately, all wb_* = 0.
